// File: rtl/dep_check_fwd_unit_pkg.sv
// Shared decode constants and tracker-entry layout for the dependency-check / forwarding unit
// and the ALU operand muxes that consume its selects.
package dep_check_fwd_unit_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_LOAD    = 6'b010100;
  localparam logic [5:0] OP_STORE   = 6'b010101;
  localparam logic [2:0] OP_IMM_PFX = 3'b001;

  localparam int SEL_REGFILE = 0;

  // Tracker entry layout: {dest[REG_AW-1:0], is_load, valid}
  localparam int ENT_VLD = 0;
  localparam int ENT_LD  = 1;
  localparam int ENT_DST = 2;

  typedef enum logic [2:0] {
    CLS_OTHER = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_IMM   = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STORE = 3'd4
  } ins_class_e;

  function automatic ins_class_e classify(input logic [5:0] op);
    ins_class_e c;
    c = CLS_OTHER;
    if (op == OP_RTYPE)                c = CLS_RTYPE;
    else if (op == OP_LOAD)            c = CLS_LOAD;
    else if (op == OP_STORE)           c = CLS_STORE;
    else if (op[5:3] == OP_IMM_PFX)    c = CLS_IMM;
    return c;
  endfunction

endpackage

// File: rtl/dep_check_fwd_unit_if.sv
// Fetch-side handshake plus EX/DM control bundle of the dependency-check unit.
// The stall_cnt signal exists only when DEP_CHECK_STALL_CNT_EN is defined.
interface dep_check_fwd_unit_if #(
  parameter int INS_W     = 32,
  parameter int OP_W      = 6,
  parameter int REG_AW    = 5,
  parameter int IMM_W     = 16,
  parameter int FWD_DEPTH = 3
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic              ins_valid;
  logic [INS_W-1:0]  ins;
  logic              ins_ready;
  logic [OP_W-1:0]   op_dec;
  logic [IMM_W-1:0]  imm;
  logic              imm_sel;
  logic [SEL_W-1:0]  mux_sel_A;
  logic [SEL_W-1:0]  mux_sel_B;
  logic              mem_en_ex;
  logic              mem_rw_ex;
  logic [REG_AW-1:0] RW_dm;
  logic              mem_mux_sel_dm;
`ifdef DEP_CHECK_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    output ins_valid, ins,
    input  ins_ready, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
           mem_en_ex, mem_rw_ex, RW_dm, mem_mux_sel_dm
`ifdef DEP_CHECK_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  ins_valid, ins,
    output ins_ready, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
           mem_en_ex, mem_rw_ex, RW_dm, mem_mux_sel_dm
`ifdef DEP_CHECK_STALL_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/dep_check_fwd_unit_match.sv
// Per-operand priority encoder: youngest tracker entry writing the source register wins,
// plus a flag for a pending LOAD to that register sitting in EX (entry 1).
module dep_check_fwd_unit_match
  import dep_check_fwd_unit_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = 2
) (
  input  logic [REG_AW-1:0]                 src_i,
  input  logic [FWD_DEPTH*(REG_AW+2)-1:0]   trk_i,
  output logic [SEL_W-1:0]                  sel_o,
  output logic                              ld_hit_o
);
  localparam int EW = REG_AW + 2;

  always_comb begin
    sel_o = SEL_W'(SEL_REGFILE);
    // Scan oldest to youngest so the smallest matching stage overwrites the rest
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if ((src_i != '0) && trk_i[(k-1)*EW + ENT_VLD] &&
          (trk_i[(k-1)*EW + ENT_DST +: REG_AW] == src_i))
        sel_o = SEL_W'(k);
    end
  end

  assign ld_hit_o = (src_i != '0) && trk_i[ENT_VLD] && trk_i[ENT_LD] &&
                    (trk_i[ENT_DST +: REG_AW] == src_i);

endmodule

// File: rtl/dep_check_fwd_unit.sv
// Decode + destination tracker driving ALU forwarding selects and the load-use stall.
// Optional DEP_CHECK_STALL_CNT_EN adds a saturating stall-cycle counter.
module dep_check_fwd_unit
  import dep_check_fwd_unit_pkg::*;
#(
  parameter int INS_W     = 32,
  parameter int OP_W      = 6,
  parameter int REG_AW    = 5,
  parameter int IMM_W     = 16,
  parameter int FWD_DEPTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  dep_check_fwd_unit_if.slave bus
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);
  localparam int EW    = REG_AW + 2;
  localparam int TW    = FWD_DEPTH * EW;

  logic [OP_W-1:0]   op_f;
  logic [REG_AW-1:0] rs_f, rt_f, rd_f;
  logic [IMM_W-1:0]  imm_f;
  ins_class_e        cls;

  assign op_f  = bus.ins[INS_W-1 -: OP_W];
  assign rs_f  = bus.ins[INS_W-OP_W-1 -: REG_AW];
  assign rt_f  = bus.ins[INS_W-OP_W-REG_AW-1 -: REG_AW];
  assign rd_f  = bus.ins[INS_W-OP_W-2*REG_AW-1 -: REG_AW];
  assign imm_f = bus.ins[IMM_W-1:0];
  assign cls   = classify(6'(op_f));

  logic              dec_imm_sel, dec_mem_en, dec_mem_rw, dec_wr, rt_used;
  logic [REG_AW-1:0] dec_dst;

  always_comb begin
    dec_imm_sel = 1'b0;
    dec_mem_en  = 1'b0;
    dec_mem_rw  = 1'b0;
    dec_wr      = 1'b0;
    dec_dst     = '0;
    case (cls)
      CLS_RTYPE: begin dec_wr = 1'b1; dec_dst = rd_f; end
      CLS_IMM:   begin dec_wr = 1'b1; dec_dst = rt_f; dec_imm_sel = 1'b1; end
      CLS_LOAD:  begin dec_wr = 1'b1; dec_dst = rt_f; dec_mem_en = 1'b1; end
      CLS_STORE: begin dec_mem_en = 1'b1; dec_mem_rw = 1'b1; dec_imm_sel = 1'b1; end
      default:   ;
    endcase
  end

  // STORE keeps rt as its store-data operand even though operand B is the immediate
  assign rt_used = !(dec_imm_sel && (cls != CLS_STORE));

  logic [TW-1:0]    trk_q, trk_d;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             ld_hit_a, ld_hit_b, stall, accept;

  dep_check_fwd_unit_match #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_a (
    .src_i(rs_f), .trk_i(trk_q), .sel_o(sel_a), .ld_hit_o(ld_hit_a)
  );
  dep_check_fwd_unit_match #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_b (
    .src_i(rt_f), .trk_i(trk_q), .sel_o(sel_b), .ld_hit_o(ld_hit_b)
  );

  assign stall         = bus.ins_valid && (ld_hit_a || (rt_used && ld_hit_b));
  assign accept        = bus.ins_valid && !stall;
  assign bus.ins_ready = !stall;

  logic [OP_W-1:0]   op_dec_q, op_dec_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              imm_sel_q, imm_sel_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic              mem_en_q, mem_en_d, mem_rw_q, mem_rw_d;
  logic [REG_AW-1:0] rw_dm_q, rw_dm_d;
  logic              mem_mux_q, mem_mux_d;
  logic [EW-1:0]     ent1_d;

  always_comb begin
    op_dec_d  = '0;
    imm_d     = '0;
    imm_sel_d = 1'b0;
    sel_a_d   = '0;
    sel_b_d   = '0;
    mem_en_d  = 1'b0;
    mem_rw_d  = 1'b0;
    ent1_d    = '0;
    if (accept) begin
      op_dec_d  = op_f;
      imm_d     = imm_f;
      imm_sel_d = dec_imm_sel;
      sel_a_d   = sel_a;
      sel_b_d   = rt_used ? sel_b : '0;
      mem_en_d  = dec_mem_en;
      mem_rw_d  = dec_mem_rw;
      // r0 writes are never tracked, so r0 can neither forward nor stall
      ent1_d[ENT_VLD]            = dec_wr && (dec_dst != '0);
      ent1_d[ENT_LD]             = (cls == CLS_LOAD);
      ent1_d[ENT_DST +: REG_AW]  = dec_dst;
    end
  end

  generate
    if (FWD_DEPTH > 1) begin : g_shift
      assign trk_d = {trk_q[TW-EW-1:0], ent1_d};
    end else begin : g_single
      assign trk_d = ent1_d;
    end
  endgenerate

  // DM stage is fed from entry 1 directly so it exists for any FWD_DEPTH
  assign rw_dm_d   = trk_q[ENT_VLD] ? trk_q[ENT_DST +: REG_AW] : '0;
  assign mem_mux_d = trk_q[ENT_VLD] && trk_q[ENT_LD];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_dec_q  <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
      rw_dm_q   <= '0;
      mem_mux_q <= 1'b0;
      trk_q     <= '0;
    end else begin
      op_dec_q  <= op_dec_d;
      imm_q     <= imm_d;
      imm_sel_q <= imm_sel_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      mem_en_q  <= mem_en_d;
      mem_rw_q  <= mem_rw_d;
      rw_dm_q   <= rw_dm_d;
      mem_mux_q <= mem_mux_d;
      trk_q     <= trk_d;
    end
  end

  assign bus.op_dec         = op_dec_q;
  assign bus.imm            = imm_q;
  assign bus.imm_sel        = imm_sel_q;
  assign bus.mux_sel_A      = sel_a_q;
  assign bus.mux_sel_B      = sel_b_q;
  assign bus.mem_en_ex      = mem_en_q;
  assign bus.mem_rw_ex      = mem_rw_q;
  assign bus.RW_dm          = rw_dm_q;
  assign bus.mem_mux_sel_dm = mem_mux_q;

`ifdef DEP_CHECK_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dep_check_fwd_unit.sv
// Directed bench for dep_check_fwd_unit: forwarding distances, load-use stall, decode, r0, reset.
module tb_dep_check_fwd_unit;
  localparam int FWD_DEPTH = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dep_check_fwd_unit_if #(.INS_W(32), .OP_W(6), .REG_AW(5), .IMM_W(16), .FWD_DEPTH(FWD_DEPTH)) bus ();

  dep_check_fwd_unit #(.INS_W(32), .OP_W(6), .REG_AW(5), .IMM_W(16), .FWD_DEPTH(FWD_DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i);
    bus.ins_valid = v;
    bus.ins       = i;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drive(1'b0, 32'h0);
    repeat (FWD_DEPTH + 1) tick();
  endtask

  logic [31:0] gap_exp [3];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.ins_valid = 1'b0;
    bus.ins       = 32'h0;
    gap_exp[0] = 32'd2;
    gap_exp[1] = 32'd3;
    gap_exp[2] = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  32'(bus.ins_ready), 32'd1);
    chk("rst_op",     32'(bus.op_dec), 32'd0);
    chk("rst_selA",   32'(bus.mux_sel_A), 32'd0);
    chk("rst_rwdm",   32'(bus.RW_dm), 32'd0);
    chk("rst_memen",  32'(bus.mem_en_ex), 32'd0);
    reset = 1'b1;
    tick();

    // R r3=r1+r2 then R r4=r3+r1
    drive(1'b1, 32'h00221800);
    chk("t1_ready0", 32'(bus.ins_ready), 32'd1);
    tick();
    drive(1'b1, 32'h00612000);
    chk("t1_ready1", 32'(bus.ins_ready), 32'd1);
    tick();
    chk("t1_selA", 32'(bus.mux_sel_A), 32'd1);
    chk("t1_selB", 32'(bus.mux_sel_B), 32'd0);
    chk("t1_rwdm", 32'(bus.RW_dm), 32'd3);
    drive(1'b0, 32'h0);
    tick();
    chk("t1_bubble_op", 32'(bus.op_dec), 32'd0);
    chk("t1_rwdm2",     32'(bus.RW_dm), 32'd4);
    flush();

    // Writer of r3, n unrelated ops, reader of r3 as rt
    for (int n = 1; n <= 3; n++) begin
      drive(1'b1, 32'h00221800);
      tick();
      for (int j = 0; j < n; j++) begin
        drive(1'b1, 32'h00000000);
        tick();
      end
      drive(1'b1, 32'h00A33000);
      tick();
      chk($sformatf("t2_gap%0d_selB", n), 32'(bus.mux_sel_B), gap_exp[n-1]);
      chk($sformatf("t2_gap%0d_selA", n), 32'(bus.mux_sel_A), 32'd0);
      flush();
    end

    // LOAD r1,0(r4) then R r4=r5+r1 : one stall cycle
    drive(1'b1, 32'h50810000);
    tick();
    chk("t3_ld_memen", 32'(bus.mem_en_ex), 32'd1);
    chk("t3_ld_rw",    32'(bus.mem_rw_ex), 32'd0);
    chk("t3_ld_op",    32'(bus.op_dec), 32'h14);
    drive(1'b1, 32'h00A12000);
    chk("t3_stall", 32'(bus.ins_ready), 32'd0);
    tick();
    chk("t3_bubble_memen", 32'(bus.mem_en_ex), 32'd0);
    chk("t3_bubble_op",    32'(bus.op_dec), 32'd0);
    chk("t3_rwdm",         32'(bus.RW_dm), 32'd1);
    chk("t3_memmux",       32'(bus.mem_mux_sel_dm), 32'd1);
    chk("t3_ready_again",  32'(bus.ins_ready), 32'd1);
    tick();
    chk("t3_selB", 32'(bus.mux_sel_B), 32'd2);
    chk("t3_selA", 32'(bus.mux_sel_A), 32'd0);
    chk("t3_memmux_bubble", 32'(bus.mem_mux_sel_dm), 32'd0);
    flush();

    // r1 writer, imm-ALU reading r1 as rt (rt unused), then STORE of r1
    drive(1'b1, 32'h00000800);
    tick();
    drive(1'b1, 32'h34C10005);
    tick();
    chk("t4_imm",    32'(bus.imm), 32'h0005);
    chk("t4_immsel", 32'(bus.imm_sel), 32'd1);
    chk("t4_selB",   32'(bus.mux_sel_B), 32'd0);
    chk("t4_op",     32'(bus.op_dec), 32'h0D);
    drive(1'b1, 32'h54410000);
    tick();
    chk("t4_st_selB",  32'(bus.mux_sel_B), 32'd1);
    chk("t4_st_rw",    32'(bus.mem_rw_ex), 32'd1);
    chk("t4_st_memen", 32'(bus.mem_en_ex), 32'd1);
    chk("t4_st_selA",  32'(bus.mux_sel_A), 32'd0);
    flush();

    // Register 0: never forwarded, never stalls
    drive(1'b1, 32'h34200007);
    tick();
    drive(1'b1, 32'h00000800);
    tick();
    chk("t5_r0_selA", 32'(bus.mux_sel_A), 32'd0);
    chk("t5_r0_selB", 32'(bus.mux_sel_B), 32'd0);
    drive(1'b1, 32'h50800000);
    tick();
    drive(1'b1, 32'h00001000);
    chk("t5_r0_nostall", 32'(bus.ins_ready), 32'd1);
    tick();
    chk("t5_r0_ld_selB", 32'(bus.mux_sel_B), 32'd0);
    flush();

    // Back-to-back writes to r3: younger shadows older
    drive(1'b1, 32'h00221800);
    tick();
    drive(1'b1, 32'h00221800);
    tick();
    drive(1'b1, 32'h00A33000);
    tick();
    chk("t5_shadow_selB", 32'(bus.mux_sel_B), 32'd1);
    flush();

    // Reset asserted during a load-use stall
    drive(1'b1, 32'h50810000);
    tick();
    drive(1'b1, 32'h00A12000);
    chk("t5_pre_rst_stall", 32'(bus.ins_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(bus.ins_ready), 32'd1);
    chk("t5_rst_memen", 32'(bus.mem_en_ex), 32'd0);
    chk("t5_rst_op",    32'(bus.op_dec), 32'd0);
    reset = 1'b1;
    tick();
    chk("t5_post_rst_selB", 32'(bus.mux_sel_B), 32'd0);
    chk("t5_post_rst_op",   32'(bus.op_dec), 32'd0);
    flush();

`ifdef DEP_CHECK_STALL_CNT_EN
    chk("t6_cnt_cleared", 32'(bus.stall_cnt), 32'd0);
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 32'h50810000);
      tick();
      drive(1'b1, 32'h00A12000);
      tick();
      tick();
      flush();
    end
    chk("t6_cnt3", 32'(bus.stall_cnt), 32'd3);
    reset = 1'b0;
    #1;
    chk("t6_cnt_rst", 32'(bus.stall_cnt), 32'd0);
    reset = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
